// File: rtl/serial_alu_if.sv
// serial_alu_if: request/response bundle for the bit-serial ALU.
//   in_valid/in_ready  - request handshake qualifying op, a, b
//   op, a, b           - operation select and operands
//   out_valid/out_ready- response handshake qualifying result and flags
//   result, zero, carry, overflow - registered result and flags
// Modports: master drives requests and consumes results, slave is the ALU.
interface serial_alu_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, carry, overflow
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, carry, overflow
  );
endinterface

// File: rtl/serial_alu.sv
// serial_alu: bit-serial ALU, one operand bit per clock, LSB first, through
// a single 1-bit slice with a registered carry.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - serial_alu_if.slave: in_valid/in_ready accept op, a, b;
//           out_valid/out_ready deliver result, zero, carry, overflow.
// Ops: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 NOR, 110 SLT, 111 PASS_A.
// An accepted request spends WIDTH cycles in RUN, then holds its result in
// DONE until the consumer takes it.
module serial_alu #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  serial_alu_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:1] sh_q, sh_nx;
  logic             cy_q;

  logic             bit_out, cout, v_int, last;
  logic [WIDTH-1:0] res_fin;
  logic             c_fin, v_fin;

  logic [WIDTH-1:0] res_q;
  logic             zero_q, carry_q, ovf_q;

  // SUB and SLT run as a + ~b + 1: b is inverted here and carry starts at 1.
  function automatic logic subtracts(input logic [2:0] o);
    return (o == OP_SUB) || (o == OP_SLT);
  endfunction

  // One-bit ALU slice; returns {carry_out, result_bit}.
  function automatic logic [1:0] alu_slice(input logic [2:0] o, input logic x,
                                           input logic y, input logic ci);
    logic yb, s, co, r;
    yb = y ^ subtracts(o);
    s  = x ^ yb ^ ci;
    co = (x & yb) | (x & ci) | (yb & ci);
    case (o)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_NOR:  r = ~(x | y);
      OP_PASS: r = x;
      default: r = s;
    endcase
    return {co, r};
  endfunction

  assign last = (cnt == LAST);

  // Slice evaluation and the final result/flags as they would be latched
  // on the last RUN edge.
  always_comb begin
    {cout, bit_out} = alu_slice(op_q, a_q[0], b_q[0], cy_q);
    v_int   = cy_q ^ cout;
    res_fin = {bit_out, sh_q};
    c_fin   = 1'b0;
    v_fin   = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        c_fin = cout;
        v_fin = v_int;
      end
      OP_SLT:  res_fin = {{(WIDTH-1){1'b0}}, bit_out ^ v_int};
      default: ;
    endcase
  end

  // New bits enter at the top so that after WIDTH shifts bit 0 is at the LSB.
  always_comb begin
    sh_nx = sh_q;
    for (int i = 1; i < WIDTH - 1; i++) sh_nx[i] = sh_q[i+1];
    sh_nx[WIDTH-1] = bit_out;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == RUN) cnt <= cnt + CNT_W'(1);
      else              cnt <= '0;
      if (state == RUN && last) begin
        res_q   <= res_fin;
        zero_q  <= (res_fin == '0);
        carry_q <= c_fin;
        ovf_q   <= v_fin;
      end
    end
  end

  // Operand, shift and carry registers carry no reset: they are only
  // observed through res_q, which is written after a full RUN pass.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.in_valid) begin
      op_q <= bus.op;
      a_q  <= bus.a;
      b_q  <= bus.b;
      cy_q <= subtracts(bus.op);
    end else if (state == RUN) begin
      a_q  <= a_q >> 1;
      b_q  <= b_q >> 1;
      sh_q <= sh_nx;
      cy_q <= cout;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = res_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: directed bench for serial_alu at WIDTH=8. An arithmetic
// reference model tracks the expected handshake and result; one compare
// process checks the outputs on every falling edge, and the directed
// sequences add hand-computed literal expectations.
module tb_serial_alu;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         v;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   edge_no = 0;

  serial_alu_if #(.WIDTH(W)) bus ();

  serial_alu #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference arithmetic in plain integer terms.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t       e;
    logic [W:0] s;
    e = '0;
    case (o)
      3'b000: e.res = x & y;
      3'b001: e.res = x | y;
      3'b010: begin
        s = {1'b0, x} + {1'b0, y};
        e.res = s[W-1:0];
        e.c = s[W];
        e.v = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
      end
      3'b011: begin
        s = {1'b0, x} + {1'b0, ~y} + 1;
        e.res = s[W-1:0];
        e.c = (x >= y);
        e.v = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
      end
      3'b100: e.res = x ^ y;
      3'b101: e.res = ~(x | y);
      3'b110: e.res = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      default: e.res = x;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Model state: one request in flight at most.
  bit   pending = 0;
  int   acc_e = 0;
  exp_t exp_v = '0;
  exp_t last_v = '0;

  always @(negedge rst_n) begin
    pending = 0;
    last_v  = '0;
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      if (pending) begin
        if (edge_no >= acc_e + W && bus.out_ready) begin
          pending = 0;
          last_v  = exp_v;
        end
      end else if (bus.in_valid) begin
        pending = 1;
        acc_e   = edge_no + 1;
        exp_v   = model(bus.op, bus.a, bus.b);
      end
    end
    edge_no++;
  end

  always @(negedge clk) begin
    bit   m_ovld;
    exp_t cur;
    if (rst_n !== 1'b1) begin
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_result", bus.result, 0);
    end else begin
      m_ovld = pending && (edge_no >= acc_e + W);
      cur = m_ovld ? exp_v : last_v;
      check("cyc_in_ready", bus.in_ready, !pending);
      check("cyc_out_valid", bus.out_valid, m_ovld);
      check("cyc_result", bus.result, cur.res);
      check("cyc_zero", bus.zero, cur.z);
      check("cyc_carry", bus.carry, cur.c);
      check("cyc_overflow", bus.overflow, cur.v);
    end
  end

  task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int hold, output exp_t got, output int acc);
    int lat;
    @(negedge clk);
    bus.op = o; bus.a = x; bus.b = y; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = edge_no;
    bus.in_valid = 1'b0;
    bus.a = ~x; bus.b = ~y; bus.op = ~o;
    lat = 1;
    while (!bus.out_valid && lat < 4 * W) begin
      @(posedge clk);
      #1;
      lat++;
    end
    // Counting the accept edge itself, out_valid follows W+1 edges.
    check("latency", lat, W + 1);
    got = {bus.result, bus.zero, bus.carry, bus.overflow};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_result", bus.result, got.res);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    check("back_to_idle", bus.in_ready, 1);
  endtask

  logic [2:0] ops_t [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [W-1:0] res_t [8] = '{8'h05, 8'hAF, 8'hB4, 8'h96, 8'hAA, 8'h50, 8'h01, 8'hA5};

  initial begin
    exp_t g;
    int   acc, prev;
    rst_n = 1'b1;
    bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("init_in_ready", bus.in_ready, 1);
    check("init_out_valid", bus.out_valid, 0);
    check("init_result", bus.result, 0);
    check("init_flags", {bus.zero, bus.carry, bus.overflow}, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    do_op(3'd2, 8'h7F, 8'h01, 0, g, acc);
    check("add7f_res", g.res, 8'h80);
    check("add7f_czv", {g.c, g.z, g.v}, 3'b001);
    do_op(3'd2, 8'hFF, 8'h01, 0, g, acc);
    check("addff_res", g.res, 8'h00);
    check("addff_czv", {g.c, g.z, g.v}, 3'b110);
    do_op(3'd3, 8'h05, 8'h05, 0, g, acc);
    check("sub55_res", g.res, 8'h00);
    check("sub55_czv", {g.c, g.z, g.v}, 3'b110);
    do_op(3'd3, 8'h03, 8'h05, 0, g, acc);
    check("sub35_res", g.res, 8'hFE);
    check("sub35_c", g.c, 0);
    do_op(3'd6, 8'h80, 8'h01, 0, g, acc);
    check("slt_neg_res", g.res, 8'h01);
    check("slt_neg_cv", {g.c, g.v}, 2'b00);
    do_op(3'd6, 8'h01, 8'h80, 0, g, acc);
    check("slt_pos_res", g.res, 8'h00);
    check("slt_pos_cv", {g.c, g.v}, 2'b00);

    do_op(3'd0, 8'hA5, 8'h0F, 5, g, acc);
    check("bp_and_res", g.res, 8'h05);

    prev = 0;
    for (int i = 0; i < 8; i++) begin
      do_op(ops_t[i], 8'hA5, 8'h0F, 0, g, acc);
      check("b2b_res", g.res, res_t[i]);
      if (i > 0) check("b2b_interval", acc - prev, W + 2);
      prev = acc;
    end

    @(negedge clk);
    bus.op = 3'd2; bus.a = 8'h11; bus.b = 8'h22; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrun_out_valid", bus.out_valid, 0);
    check("midrun_result", bus.result, 0);
    check("midrun_in_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("rst_wins_in_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_out_valid", bus.out_valid, 0);
    do_op(3'd2, 8'h10, 8'h20, 0, g, acc);
    check("fresh_add_res", g.res, 8'h30);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_alu.md
Name: serial_alu

Overview:
- Parametrised, bit-serial successor to the single-bit ALU slice.
- Processes WIDTH-bit operands one bit per clock, LSB first, through one internal 1-bit ALU slice with a registered carry.
- Valid/ready handshakes on input and output, so it drops into multi-cycle datapaths where area matters more than latency.
- Also produces zero, carry and overflow flags and a set-less-than result.

Parameters:
- WIDTH, 16, operand and result width in bits (legal range 2 to 64).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request; qualifies op, a, b.
- in_ready  output  1  block can accept an operation this cycle.
- op  input  3  operation select: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 NOR, 110 SLT, 111 PASS_A.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  computed result.
- zero  output  1  result == 0.
- carry  output  1  carry out of MSB, ADD/SUB only.
- overflow  output  1  signed overflow, ADD/SUB only.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE; bit counter is cleared.
  - in_ready=1, out_valid=0, result=0, zero=0, carry=0, overflow=0.
  - An in-flight operation is discarded, with no partial output.
- States and transitions:
  - IDLE: in_ready=1. On in_valid && in_ready at an edge, latch op, a, b and go to RUN. Carry init is 1 for SUB/SLT (B inverted), 0 otherwise. Counter=0.
  - RUN: in_ready=0, out_valid=0. Each edge computes bit[counter] from a[counter], b[counter] (inverted for SUB/SLT) and the carry register. It shifts the bit into the result shift register, updates carry and increments the counter. After the edge that computes bit WIDTH-1, go to DONE.
  - DONE: out_valid=1, in_ready=0. result and flags are held stable until out_valid && out_ready at an edge, then return to IDLE.
- Timing:
  - Latency: accept at edge k gives out_valid=1 in the cycle after edge k+WIDTH.
  - Minimum initiation interval is WIDTH+2 cycles (IDLE cycle, WIDTH RUN cycles, DONE cycle).
  - No new input is accepted in DONE, even when out_ready is high.
  - in_valid and operands are ignored outside IDLE.
  - Latched operands are unaffected if a/b change after acceptance.
- Arithmetic and flags:
  - ADD computes a+b mod 2^WIDTH. SUB computes a+~b+1.
  - carry = final carry out for ADD/SUB. For SUB this means 1 = no borrow, i.e. a >= b unsigned.
  - overflow = carry-into-MSB XOR carry-out-of-MSB for ADD/SUB.
  - SLT: internally performs SUB. The final result is {WIDTH-1 zeros, diff_msb XOR overflow_int} (signed compare). carry=0, overflow=0.
  - AND/OR/XOR/NOR/PASS_A are bitwise. carry=0, overflow=0.
  - zero is evaluated on the final result, including SLT.
- Flag/result update: result and flags change only on entry to DONE and on reset. The outputs are registered, not driven from the shift register mid-RUN; result holds its previous value until DONE.
- Simultaneous events:
  - Reset asserted on the same edge as an accept wins: the block stays in IDLE.
  - out_ready with out_valid low has no effect.

Test Plan (WIDTH=8):
- ADD a=0x7F b=0x01 -> out_valid exactly 9 edges after accept; result=0x80, carry=0, overflow=1, zero=0.
- ADD a=0xFF b=0x01 -> result=0x00, carry=1, overflow=0, zero=1.
- SUB a=0x05 b=0x05 -> result=0x00, zero=1, carry=1, overflow=0. Then SUB a=0x03 b=0x05 -> result=0xFE, carry=0.
- SLT a=0x80 b=0x01 -> result=0x01. SLT a=0x01 b=0x80 -> result=0x00. carry=overflow=0 in both.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with a=0xA5, b=0x0F.
  - AND yields result=0x05, stable throughout the hold; in_ready=0 and in_valid ignored.
  - out_ready=1 gives return to IDLE on the next edge.
  - All eight ops are run back-to-back, each initiation WIDTH+2=10 cycles apart.
- Assert rst_n=0 mid-RUN after 3 RUN cycles, asynchronously between edges -> out_valid=0, result=0 and in_ready=1 immediately. No stale result appears after reset release; a fresh ADD 0x10+0x20 -> 0x30.
